vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_DISPLAY, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FRONT 16, H_SYNC 96, H_BACK 48; H_TOTAL = sum of the four horizontal parameters (800).
REQ-003 SHALL have parameters V_DISPLAY 480, V_FRONT 10, V_SYNC 2, V_BACK 33; V_TOTAL = sum of the four vertical parameters (525).
REQ-004 SHALL have parameters H_SYNC_POL 0 and V_SYNC_POL 0, the asserted sync level (0 = active-low).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset; synchronous and active-high.
REQ-007 SHALL have port pix_en, input, 1 bit: pixel tick; counters advance only on cycles with pix_en=1.
REQ-008 SHALL have port hpos, output, 10 bits: current column, 0..H_TOTAL-1.
REQ-009 SHALL have port vpos, output, 10 bits: current line, 0..V_TOTAL-1.
REQ-010 SHALL have port hsync, output, 1 bit: horizontal sync.
REQ-011 SHALL have port vsync, output, 1 bit: vertical sync.
REQ-012 SHALL have port visible, output, 1 bit: high while hpos<H_DISPLAY and vpos<V_DISPLAY.
REQ-013 SHALL have port line_start, output, 1 bit: single-clk pulse in the cycle hpos becomes 0.
REQ-014 SHALL have port frame_start, output, 1 bit: single-clk pulse in the cycle (hpos,vpos) becomes (0,0).
REQ-015 SHALL have port frame_count, output, 10 bits: frames begun since reset, modulo 1024.

Function
REQ-016 On a pix_en cycle, hpos SHALL increment by 1, and wrap to 0 after H_TOTAL-1.
REQ-017 vpos SHALL increment only when hpos wraps; it SHALL wrap to 0 after V_TOTAL-1, in the same cycle hpos wraps.
REQ-018 With pix_en=0, hpos, vpos, hsync, vsync, visible and frame_count SHALL hold.
REQ-019 With pix_en=0, line_start and frame_start SHALL be 0.
REQ-020 hsync SHALL equal H_SYNC_POL while H_DISPLAY+H_FRONT <= hpos < H_DISPLAY+H_FRONT+H_SYNC (656..751), and its inverse otherwise.
REQ-021 vsync SHALL equal V_SYNC_POL while V_DISPLAY+V_FRONT <= vpos < V_DISPLAY+V_FRONT+V_SYNC (490..491), and its inverse otherwise.
REQ-022 hsync, vsync and visible SHALL be registered, decoded from next-state counter values, so they are consistent with hpos/vpos in the same cycle (zero relative latency, no combinational path from counters).
REQ-023 line_start and frame_start SHALL be registered and asserted in the same cycle as the new position; each is high for at most one clk per event.
REQ-024 frame_count SHALL increment by 1 in the cycle frame_start is asserted, and wrap 1023->0.
REQ-025 Counter arithmetic SHALL be 10-bit unsigned; H_TOTAL and V_TOTAL SHALL be <= 1024 (elaboration-time check).
REQ-026 When pix_en=1 every cycle, the period SHALL be H_TOTAL clks per line and H_TOTAL*V_TOTAL clks per frame, with no dropped or repeated positions.

Reset
REQ-027 While rst=1: hpos=H_TOTAL-1, vpos=V_TOTAL-1, frame_count=1023, visible=0, hsync=!H_SYNC_POL, vsync=!V_SYNC_POL, line_start=0, frame_start=0.
REQ-028 The first pix_en cycle after rst falls SHALL wrap to (0,0), assert line_start and frame_start, and set frame_count=0.
REQ-029 rst asserted mid-frame SHALL take effect on the next clk edge, regardless of pix_en; no partial pulse SHALL follow.

Structure
REQ-030 A shared package vga_timing_pkg SHALL hold the 640x480 timing constants and the position width (10).
REQ-031 One sub-module, vga_axis_counter (wrap counter with enable, period parameter, wrap output), SHALL be instantiated twice: horizontal and vertical.

Verification
REQ-032 Scenario: rst for 3 clks, then pix_en=1 -> cycle 1 after release hpos=0, vpos=0, visible=1, frame_start=1, line_start=1, frame_count=0.
REQ-033 Scenario: pix_en=1 continuous for 2 frames -> hsync low exactly for hpos 656..751, vsync low exactly for vpos 490..491, frame_start period 420000 clks, frame_count=1 at the second frame start.
REQ-034 Scenario: pix_en toggling 1,0,1,0 -> position advances every other clk, pulses never exceed 1 clk, and line period is 1600 clks.
REQ-035 Scenario: hpos=799 and vpos=524 with pix_en=1 -> next cycle (0,0), frame_start=1, line_start=1; at hpos=799 and vpos=100 -> (0,101), line_start=1, frame_start=0.
REQ-036 Scenario: rst pulsed at (hpos=300, vpos=200) -> next clk shows the REQ-027 values, with no frame_start until the first pix_en after release.
REQ-037 Scenario: frame_count at 1023 and frame wraps -> frame_count=0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, position type and decode helpers.
// Default values describe the 640x480 @ 60 Hz mode.
package vga_timing_pkg;

    // Width of every position counter and of the frame counter.
    localparam int unsigned POS_W = 10;
    localparam int unsigned POS_LIMIT = 1 << POS_W;

    typedef logic [POS_W-1:0] pos_t;

    // Horizontal timing, in pixel ticks.
    localparam int unsigned H_DISPLAY_DEF = 640;
    localparam int unsigned H_FRONT_DEF = 16;
    localparam int unsigned H_SYNC_DEF = 96;
    localparam int unsigned H_BACK_DEF = 48;

    // Vertical timing, in lines.
    localparam int unsigned V_DISPLAY_DEF = 480;
    localparam int unsigned V_FRONT_DEF = 10;
    localparam int unsigned V_SYNC_DEF = 2;
    localparam int unsigned V_BACK_DEF = 33;

    // True when p < lim, compared in 32 bits so lim may be POS_LIMIT.
    function automatic logic below(input pos_t p, input int unsigned lim);
        return 32'(p) < lim;
    endfunction

    // True when lo <= p < hi.
    function automatic logic in_window(
        input pos_t        p,
        input int unsigned lo,
        input int unsigned hi
    );
        return !below(p, lo) && below(p, hi);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrap-around position counter for one display axis.
// Ports: clk, rst (sync, active-high), en (advance), pos (current),
//        pos_next (value pos takes at the next edge), wrap (en at last).
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned PERIOD = 800
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output pos_t pos,
    output pos_t pos_next,
    output logic wrap
);

    if (PERIOD < 2 || PERIOD > POS_LIMIT) begin : g_bad_period
        $error("vga_axis_counter: PERIOD must be within 2..1024");
    end

    localparam pos_t LAST = pos_t'(PERIOD - 1);

    pos_t cnt_q;
    pos_t cnt_d;
    logic wrap_c;

    always_comb begin
        wrap_c = en && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = wrap_c ? '0 : cnt_q + pos_t'(1);
        end
    end

    // Reset parks the counter on its last value so the first enabled
    // tick after reset lands exactly on position 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= LAST;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pos = cnt_q;
    assign pos_next = cnt_d;
    assign wrap = wrap_c;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters plus registered sync,
// visible and start-of-line/frame strobes, and a 10-bit frame counter.
// Ports: clk, rst (sync, active-high), pix_en (pixel tick),
//        hpos/vpos (position), hsync/vsync, visible,
//        line_start/frame_start (1-clk pulses), frame_count.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_DISPLAY = H_DISPLAY_DEF,
    parameter int unsigned H_FRONT = H_FRONT_DEF,
    parameter int unsigned H_SYNC = H_SYNC_DEF,
    parameter int unsigned H_BACK = H_BACK_DEF,
    parameter int unsigned V_DISPLAY = V_DISPLAY_DEF,
    parameter int unsigned V_FRONT = V_FRONT_DEF,
    parameter int unsigned V_SYNC = V_SYNC_DEF,
    parameter int unsigned V_BACK = V_BACK_DEF,
    parameter bit          H_SYNC_POL = 1'b0,
    parameter bit          V_SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_en,
    output logic [POS_W-1:0] hpos,
    output logic [POS_W-1:0] vpos,
    output logic             hsync,
    output logic             vsync,
    output logic             visible,
    output logic             line_start,
    output logic             frame_start,
    output logic [POS_W-1:0] frame_count
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_LO = H_DISPLAY + H_FRONT;
    localparam int unsigned HS_HI = HS_LO + H_SYNC;
    localparam int unsigned VS_LO = V_DISPLAY + V_FRONT;
    localparam int unsigned VS_HI = VS_LO + V_SYNC;

    if (H_TOTAL > POS_LIMIT) begin : g_bad_h_total
        $error("vga_timing_gen: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > POS_LIMIT) begin : g_bad_v_total
        $error("vga_timing_gen: V_TOTAL exceeds 1024");
    end

    pos_t h_pos;
    pos_t h_next;
    logic h_wrap;
    pos_t v_pos;
    pos_t v_next;
    logic v_wrap;

    // The vertical counter is enabled only by the horizontal wrap, so
    // its own wrap already implies pix_en and the last column.
    vga_axis_counter #(
        .PERIOD(H_TOTAL)
    ) u_h_cnt (
        .clk     (clk),
        .rst     (rst),
        .en      (pix_en),
        .pos     (h_pos),
        .pos_next(h_next),
        .wrap    (h_wrap)
    );

    vga_axis_counter #(
        .PERIOD(V_TOTAL)
    ) u_v_cnt (
        .clk     (clk),
        .rst     (rst),
        .en      (h_wrap),
        .pos     (v_pos),
        .pos_next(v_next),
        .wrap    (v_wrap)
    );

    logic hsync_q;
    logic hsync_d;
    logic vsync_q;
    logic vsync_d;
    logic visible_q;
    logic visible_d;
    logic line_start_q;
    logic line_start_d;
    logic frame_start_q;
    logic frame_start_d;
    pos_t frame_count_q;
    pos_t frame_count_d;

    // Decode from the counters' next values so the registered flags line
    // up with hpos/vpos in the same cycle. When pix_en is low the next
    // values equal the current ones, so the flags hold naturally.
    always_comb begin
        hsync_d = in_window(h_next, HS_LO, HS_HI) ? H_SYNC_POL : ~H_SYNC_POL;
        vsync_d = in_window(v_next, VS_LO, VS_HI) ? V_SYNC_POL : ~V_SYNC_POL;
        visible_d = below(h_next, H_DISPLAY) && below(v_next, V_DISPLAY);
        line_start_d = h_wrap;
        frame_start_d = h_wrap && v_wrap;
        frame_count_d = frame_count_q;
        if (frame_start_d) begin
            frame_count_d = frame_count_q + pos_t'(1);
        end
    end

    // Frame counter resets to all-ones so the first frame reads as 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_q <= ~H_SYNC_POL;
            vsync_q <= ~V_SYNC_POL;
            visible_q <= 1'b0;
            line_start_q <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= '1;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            visible_q <= visible_d;
            line_start_q <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign hpos = h_pos;
    assign vpos = v_pos;
    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign visible = visible_q;
    assign line_start = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a scaled-down raster (8x6 positions).
// Expected outputs come from a cycle model queued at each driven cycle.
module tb_vga_timing_gen;

    localparam int HD = 4;
    localparam int HF = 1;
    localparam int HS = 2;
    localparam int HB = 1;
    localparam int HT = HD + HF + HS + HB;
    localparam int VD = 2;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int VT = VD + VF + VS + VB;
    localparam bit HPOL = 1'b0;
    localparam bit VPOL = 1'b1;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       vis;
        logic       ls;
        logic       fs;
        logic [9:0] fc;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pix_en = 1'b0;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       hsync;
    logic       vsync;
    logic       visible;
    logic       line_start;
    logic       frame_start;
    logic [9:0] frame_count;

    int n_chk = 0;
    int n_fail = 0;

    int   mh = HT - 1;
    int   mv = VT - 1;
    int   mfc = 1023;
    logic mls = 1'b0;
    logic mfs = 1'b0;
    obs_t sbq[$];
    obs_t e;
    obs_t o;

    vga_timing_gen #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_SYNC_POL(HPOL), .V_SYNC_POL(VPOL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_en     (pix_en),
        .hpos       (hpos),
        .vpos       (vpos),
        .hsync      (hsync),
        .vsync      (vsync),
        .visible    (visible),
        .line_start (line_start),
        .frame_start(frame_start),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    function automatic obs_t exp_of();
        obs_t x;
        x.h = 10'(mh);
        x.v = 10'(mv);
        x.hs = (mh >= HD + HF && mh < HD + HF + HS) ? HPOL : ~HPOL;
        x.vs = (mv >= VD + VF && mv < VD + VF + VS) ? VPOL : ~VPOL;
        x.vis = (mh < HD) && (mv < VD);
        x.ls = mls;
        x.fs = mfs;
        x.fc = 10'(mfc);
        return x;
    endfunction

    function automatic obs_t sample();
        obs_t x;
        x = {hpos, vpos, hsync, vsync, visible, line_start, frame_start,
             frame_count};
        return x;
    endfunction

    // Drive one clock, advance the model, queue its expectation.
    task automatic step(input logic pe, input logic rs);
        rst = rs;
        pix_en = pe;
        if (rs) begin
            mh = HT - 1;
            mv = VT - 1;
            mfc = 1023;
            mls = 1'b0;
            mfs = 1'b0;
        end else if (pe) begin
            mls = (mh == HT - 1);
            mfs = mls && (mv == VT - 1);
            if (mls) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
            if (mfs) mfc = (mfc + 1) % 1024;
        end else begin
            mls = 1'b0;
            mfs = 1'b0;
        end
        sbq.push_back(exp_of());
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(i[0], 1'b1);
            e = sbq.pop_front();
            o = sample();
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset[%0d] got=%h exp=%h", i, o, e);
            end
        end
    endtask

    task automatic test_first_release();
        step(1'b1, 1'b0);
        e = sbq.pop_front();
        o = sample();
        n_chk++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL first_release got=%h exp=%h", o, e);
        end
        n_chk++;
        if ({o.h, o.v, o.vis, o.ls, o.fs, o.fc} !== {10'd0, 10'd0, 3'b111, 10'd0}) begin
            n_fail++;
            $display("FAIL first_release_fields h=%0d v=%0d vis=%b ls=%b fs=%b fc=%0d exp 0,0,1,1,1,0",
                     o.h, o.v, o.vis, o.ls, o.fs, o.fc);
        end
    endtask

    task automatic test_two_frames();
        int last_fs = 0;
        int n_fs = 0;
        int hs_act = 0;
        int vs_act = 0;
        for (int i = 1; i <= 2 * HT * VT; i++) begin
            step(1'b1, 1'b0);
            e = sbq.pop_front();
            o = sample();
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL two_frames[%0d] got=%h exp=%h", i, o, e);
            end
            if (o.hs == HPOL) hs_act++;
            if (o.vs == VPOL) vs_act++;
            if (o.fs) begin
                n_fs++;
                n_chk++;
                if (i - last_fs != HT * VT) begin
                    n_fail++;
                    $display("FAIL frame_period got=%0d exp=%0d", i - last_fs, HT * VT);
                end
                n_chk++;
                if (o.fc !== 10'(n_fs)) begin
                    n_fail++;
                    $display("FAIL frame_count_two got=%0d exp=%0d", o.fc, n_fs);
                end
                last_fs = i;
            end
        end
        n_chk++;
        if (n_fs != 2) begin
            n_fail++;
            $display("FAIL frame_starts got=%0d exp=2", n_fs);
        end
        n_chk++;
        if (hs_act != 2 * VT * HS) begin
            n_fail++;
            $display("FAIL hsync_active got=%0d exp=%0d", hs_act, 2 * VT * HS);
        end
        n_chk++;
        if (vs_act != 2 * VS * HT) begin
            n_fail++;
            $display("FAIL vsync_active got=%0d exp=%0d", vs_act, 2 * VS * HT);
        end
    endtask

    task automatic test_boundary();
        for (int k = 0; k < 2 * HT * VT && !(mh == HT - 1 && mv == 2); k++) begin
            step(1'b1, 1'b0);
            e = sbq.pop_front();
            o = sample();
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL boundary_run got=%h exp=%h", o, e);
            end
        end
        step(1'b1, 1'b0);
        e = sbq.pop_front();
        o = sample();
        n_chk++;
        if ({o.h, o.v, o.ls, o.fs} !== {10'd0, 10'd3, 2'b10}) begin
            n_fail++;
            $display("FAIL line_wrap h=%0d v=%0d ls=%b fs=%b exp 0,3,1,0",
                     o.h, o.v, o.ls, o.fs);
        end
        for (int k = 0; k < 2 * HT * VT && !(mh == HT - 1 && mv == VT - 1); k++) begin
            step(1'b1, 1'b0);
            e = sbq.pop_front();
            o = sample();
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL boundary_run2 got=%h exp=%h", o, e);
            end
        end
        step(1'b1, 1'b0);
        e = sbq.pop_front();
        o = sample();
        n_chk++;
        if ({o.h, o.v, o.ls, o.fs} !== {10'd0, 10'd0, 2'b11}) begin
            n_fail++;
            $display("FAIL frame_wrap_pos h=%0d v=%0d ls=%b fs=%b exp 0,0,1,1",
                     o.h, o.v, o.ls, o.fs);
        end
        n_chk++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL frame_wrap_all got=%h exp=%h", o, e);
        end
    endtask

    task automatic test_toggle();
        int   last_ls = -1;
        logic prev_ls = 1'b0;
        logic prev_fs = 1'b0;
        step(1'b0, 1'b1);
        void'(sbq.pop_front());
        for (int i = 0; i < 8 * HT; i++) begin
            step(~i[0], 1'b0);
            e = sbq.pop_front();
            o = sample();
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL toggle[%0d] got=%h exp=%h", i, o, e);
            end
            if (o.ls || o.fs) begin
                n_chk++;
                if ((o.ls && prev_ls) || (o.fs && prev_fs)) begin
                    n_fail++;
                    $display("FAIL pulse_width cyc=%0d ls=%b%b fs=%b%b exp single",
                             i, prev_ls, o.ls, prev_fs, o.fs);
                end
            end
            if (o.ls) begin
                if (last_ls >= 0) begin
                    n_chk++;
                    if (i - last_ls != 2 * HT) begin
                        n_fail++;
                        $display("FAIL line_period got=%0d exp=%0d", i - last_ls, 2 * HT);
                    end
                end
                last_ls = i;
            end
            prev_ls = o.ls;
            prev_fs = o.fs;
        end
    endtask

    task automatic test_mid_reset();
        for (int k = 0; k < 2 * HT * VT && !(mh == 3 && mv == 2); k++) begin
            step(1'b1, 1'b0);
            e = sbq.pop_front();
            o = sample();
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL mid_run got=%h exp=%h", o, e);
            end
        end
        step(1'b0, 1'b1);
        e = sbq.pop_front();
        o = sample();
        n_chk++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL mid_reset got=%h exp=%h", o, e);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            e = sbq.pop_front();
            o = sample();
            n_chk++;
            if (o !== e || o.fs !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_after_reset[%0d] got=%h exp=%h", i, o, e);
            end
        end
        step(1'b1, 1'b0);
        e = sbq.pop_front();
        o = sample();
        n_chk++;
        if (o !== e || o.fs !== 1'b1 || o.fc !== 10'd0) begin
            n_fail++;
            $display("FAIL restart got=%h exp=%h", o, e);
        end
    endtask

    task automatic test_frame_count_wrap();
        int n_fs = 0;
        step(1'b0, 1'b1);
        void'(sbq.pop_front());
        for (int i = 0; i < 1024 * HT * VT + 1; i++) begin
            step(1'b1, 1'b0);
            e = sbq.pop_front();
            o = sample();
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL fc_run[%0d] got=%h exp=%h", i, o, e);
            end
            if (o.fs) begin
                n_fs++;
                if (n_fs == 1024) begin
                    n_chk++;
                    if (o.fc !== 10'd1023) begin
                        n_fail++;
                        $display("FAIL fc_top got=%0d exp=1023", o.fc);
                    end
                end
                if (n_fs == 1025) begin
                    n_chk++;
                    if (o.fc !== 10'd0) begin
                        n_fail++;
                        $display("FAIL fc_wrap got=%0d exp=0", o.fc);
                    end
                end
            end
        end
        n_chk++;
        if (n_fs != 1025) begin
            n_fail++;
            $display("FAIL fc_frames got=%0d exp=1025", n_fs);
        end
    endtask

    initial begin
        test_reset();
        test_first_release();
        test_two_frames();
        test_boundary();
        test_toggle();
        test_mid_reset();
        test_frame_count_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
